// File: rtl/snn_loader_pkg.sv
// Shared types and helpers for the SNN frame loader.
//   state_e    : loader control states (LOAD, START, RUN, RESULT)
//   ceil_div   : integer ceiling division used to size the chunk count
//   CHUNK_BITS : chunk payload width for the default configuration
//   CHUNKS     : chunks per frame for the default configuration
package snn_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  localparam int DEF_WORD_W          = 32;
  localparam int DEF_WORDS_PER_CHUNK = 14;
  localparam int DEF_IMG_BITS        = 800;
  localparam int CHUNK_BITS          = DEF_WORD_W * DEF_WORDS_PER_CHUNK;
  localparam int CHUNKS              = ceil_div(DEF_IMG_BITS, CHUNK_BITS);

endpackage

// File: rtl/snn_run_timer.sv
// Run-window timer for the SNN frame loader.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : restarts the count at 0 on the next edge
//   last       : high while the count sits on the final cycle of the window
// The count saturates at RUN_CYCLES-1 so the timer is quiet outside RUN.
module snn_run_timer #(
  parameter int RUN_CYCLES = 7500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic last
);

  // A one-cycle window still needs a 1-bit counter that never moves.
  localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(RUN_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Window counter: cleared by start, advances until the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (start) begin
      cnt_r <= '0;
    end else if (cnt_r != LAST_VAL) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == LAST_VAL);

endmodule

// File: rtl/snn_frame_loader.sv
// SNN frame loader: assembles a frame from fixed-size chunks, starts the
// network, clocks it for a fixed run window and returns the latched outputs.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   chunk_data/valid/last, chunk_ready : chunk input stream (valid/ready)
//   chunk_idx                          : next chunk slot to be written
//   image                              : assembled frame to the network
//   net_start, net_en                  : network start pulse and clock enable
//   net_out                            : network neuron outputs
//   result, result_valid, result_ready : latched result handshake
//   busy                               : high in START, RUN and RESULT
//   err_len                            : one-cycle pulse on a frame-length error
module snn_frame_loader
  import snn_loader_pkg::*;
#(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_CHUNK = 14,
  parameter int IMG_BITS        = 800,
  parameter int N_OUT           = 2,
  parameter int RUN_CYCLES      = 7500,
  localparam int CH_BITS        = WORD_W * WORDS_PER_CHUNK,
  localparam int N_CHUNKS       = ceil_div(IMG_BITS, CH_BITS),
  localparam int IDX_W          = $clog2(N_CHUNKS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH_BITS-1:0]  chunk_data,
  input  logic                chunk_valid,
  input  logic                chunk_last,
  output logic                chunk_ready,
  output logic [IDX_W-1:0]    chunk_idx,
  output logic [IMG_BITS-1:0] image,
  output logic                net_start,
  output logic                net_en,
  input  logic [N_OUT-1:0]    net_out,
  output logic [N_OUT-1:0]    result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy,
  output logic                err_len
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  state_e           state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic             err_nxt_s;
  logic             latch_s;
  logic             xfer_s;
  logic             timer_last_s;

  logic             chunk_ready_r;
  logic             net_start_r;
  logic             net_en_r;
  logic             result_valid_r;
  logic             busy_r;
  logic             err_len_r;
  logic [N_OUT-1:0] result_r;

  // chunk_ready_r is high exactly when the state register holds LOAD.
  assign xfer_s = chunk_valid & chunk_ready_r;

  snn_run_timer #(
    .RUN_CYCLES (RUN_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state_r == ST_START),
    .last  (timer_last_s)
  );

  // Next-state, chunk slot and length-error decode.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    err_nxt_s   = 1'b0;
    latch_s     = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (xfer_s) begin
          if (idx_r == LAST_IDX) begin
            idx_nxt_s = '0;
            if (chunk_last) begin
              state_nxt_s = ST_START;
            end else begin
              err_nxt_s = 1'b1;
            end
          end else if (chunk_last) begin
            idx_nxt_s = '0;
            err_nxt_s = 1'b1;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_START: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (timer_last_s) begin
          state_nxt_s = ST_RESULT;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RESULT: begin
        if (result_ready) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_RESULT;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // State, slot index and registered control outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_LOAD;
      idx_r          <= '0;
      err_len_r      <= 1'b0;
      chunk_ready_r  <= 1'b1;
      net_start_r    <= 1'b0;
      net_en_r       <= 1'b0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      idx_r          <= idx_nxt_s;
      err_len_r      <= err_nxt_s;
      chunk_ready_r  <= (state_nxt_s == ST_LOAD);
      net_start_r    <= (state_nxt_s == ST_START);
      net_en_r       <= (state_nxt_s == ST_RUN);
      result_valid_r <= (state_nxt_s == ST_RESULT);
      busy_r         <= (state_nxt_s != ST_LOAD);
    end
  end

  // Result capture on the final run cycle, held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= '0;
    end else if (latch_s) begin
      result_r <= net_out;
    end else begin
      result_r <= result_r;
    end
  end

  // One register slice per chunk slot; the last slot is truncated at IMG_BITS.
  for (genvar k = 0; k < N_CHUNKS; k++) begin : g_slot
    localparam int LO = k * CH_BITS;
    localparam int W  = ((IMG_BITS - LO) < CH_BITS) ? (IMG_BITS - LO) : CH_BITS;

    logic [W-1:0] slot_r;

    // Slot write on a transfer addressed to this slot.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_r <= '0;
      end else if (xfer_s && (idx_r == IDX_W'(k))) begin
        slot_r <= chunk_data[W-1:0];
      end else begin
        slot_r <= slot_r;
      end
    end

    assign image[LO +: W] = slot_r;
  end

  assign chunk_ready  = chunk_ready_r;
  assign chunk_idx    = idx_r;
  assign net_start    = net_start_r;
  assign net_en       = net_en_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign err_len      = err_len_r;

endmodule

// File: tb/tb_snn_frame_loader.sv
// Directed self-checking bench for snn_frame_loader: default configuration
// plus a small instance (8x4-bit chunks, 64-bit frame, 1-cycle run window).
module tb_snn_frame_loader;

  localparam int RUN = 7500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration DUT
  logic [447:0] chunk_data = '0;
  logic         chunk_valid = 1'b0, chunk_last = 1'b0, chunk_ready;
  logic [1:0]   chunk_idx;
  logic [799:0] image;
  logic         net_start, net_en;
  logic [1:0]   net_out = 2'b00;
  logic [1:0]   result;
  logic         result_valid, result_ready = 1'b0, busy, err_len;

  // Small-configuration DUT
  logic [31:0]  s_chunk_data = '0;
  logic         s_chunk_valid = 1'b0, s_chunk_last = 1'b0, s_chunk_ready;
  logic [1:0]   s_chunk_idx;
  logic [63:0]  s_image;
  logic         s_net_start, s_net_en;
  logic [1:0]   s_net_out = 2'b00;
  logic [1:0]   s_result;
  logic         s_result_valid, s_result_ready = 1'b0, s_busy, s_err_len;

  snn_frame_loader dut (
    .clk(clk), .rst_n(rst_n),
    .chunk_data(chunk_data), .chunk_valid(chunk_valid), .chunk_last(chunk_last),
    .chunk_ready(chunk_ready), .chunk_idx(chunk_idx), .image(image),
    .net_start(net_start), .net_en(net_en), .net_out(net_out),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .err_len(err_len)
  );

  snn_frame_loader #(
    .WORD_W(8), .WORDS_PER_CHUNK(4), .IMG_BITS(64), .N_OUT(2), .RUN_CYCLES(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .chunk_data(s_chunk_data), .chunk_valid(s_chunk_valid), .chunk_last(s_chunk_last),
    .chunk_ready(s_chunk_ready), .chunk_idx(s_chunk_idx), .image(s_image),
    .net_start(s_net_start), .net_en(s_net_en), .net_out(s_net_out),
    .result(s_result), .result_valid(s_result_valid), .result_ready(s_result_ready),
    .busy(s_busy), .err_len(s_err_len)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [799:0] obs, input logic [799:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Sends a correct two-chunk frame and follows it through START and RUN
  // into RESULT; fin is driven on the final RUN cycle, ~fin elsewhere.
  task automatic run_frame(input logic [447:0] d0, input logic [447:0] d1, input logic [1:0] fin);
    int en_cnt, ns_cnt, lat;
    bit got;
    chunk_valid = 1'b1; chunk_data = d0; chunk_last = 1'b0;
    net_out = ~fin;
    step();
    chk("idx_after_c0", chunk_idx, 2'd1);
    chunk_data = d1; chunk_last = 1'b1;
    step();
    chk("start_pulse", net_start, 1'b1);
    chk("start_en", net_en, 1'b0);
    chk("start_ready", chunk_ready, 1'b0);
    chk("start_busy", busy, 1'b1);
    chk("start_idx", chunk_idx, 2'd0);
    chk("frame_image", image, {d1[351:0], d0});
    chunk_valid = 1'b0; chunk_last = 1'b0;
    en_cnt = 0; ns_cnt = 0; lat = 0; got = 1'b0;
    for (int i = 0; i < 10000 && !got; i++) begin
      step();
      lat++;
      if (result_valid) begin
        got = 1'b1;
      end else begin
        if (net_en) en_cnt++;
        if (net_start) ns_cnt++;
        net_out = (net_en && en_cnt == RUN) ? fin : ~fin;
      end
    end
    chk("result_valid_seen", got, 1'b1);
    chk("latency", lat, 1 + RUN);
    chk("net_en_cycles", en_cnt, RUN);
    chk("extra_start", ns_cnt, 0);
    chk("result_val", result, fin);
    chk("result_en", net_en, 1'b0);
    chk("result_ready_low", chunk_ready, 1'b0);
    chk("result_busy", busy, 1'b1);
    net_out = ~fin;
  endtask

  initial begin
    logic [447:0] ones, fives, pa, pb, pc, pd, pe;
    int acc, s_en, rv_at;
    ones  = {448{1'b1}};
    fives = {112{4'h5}};
    pa    = {112{4'hA}};
    pb    = {112{4'h3}};
    pc    = {112{4'hC}};
    pd    = {112{4'h9}};
    pe    = {112{4'h6}};

    // Reset state
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_idx", chunk_idx, 2'd0);
    chk("rst_image", image, 800'd0);
    chk("rst_result", result, 2'b00);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_en", net_en, 1'b0);
    chk("rst_start", net_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_len, 1'b0);
    chk("rst_ready", chunk_ready, 1'b1);

    // Nominal frame
    run_frame(ones, fives, 2'b10);

    // Backpressure, with a chunk already offered during RESULT
    chunk_valid = 1'b1; chunk_data = pa; chunk_last = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("bp_rv", result_valid, 1'b1);
      chk("bp_result", result, 2'b10);
      chk("bp_ready", chunk_ready, 1'b0);
      chk("bp_idx", chunk_idx, 2'd0);
    end
    result_ready = 1'b1;
    step();
    chk("rel_rv", result_valid, 1'b0);
    chk("rel_ready", chunk_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);
    chk("rel_idx", chunk_idx, 2'd0);
    result_ready = 1'b0;

    // Long frame: the held chunk is taken now, second chunk also last=0
    step();
    chk("long_idx1", chunk_idx, 2'd1);
    chunk_data = pb;
    step();
    chk("long_err", err_len, 1'b1);
    chk("long_idx0", chunk_idx, 2'd0);
    chk("long_busy", busy, 1'b0);
    chk("long_image", image, {pb[351:0], pa});
    chunk_valid = 1'b0;
    step();
    chk("long_err_clr", err_len, 1'b0);
    chk("long_nostart", net_start, 1'b0);

    // Short frame: single chunk flagged last
    chunk_valid = 1'b1; chunk_data = pc; chunk_last = 1'b1;
    step();
    chk("short_err", err_len, 1'b1);
    chk("short_idx", chunk_idx, 2'd0);
    chk("short_nostart", net_start, 1'b0);
    chk("short_busy", busy, 1'b0);
    chk("short_image", image, {pb[351:0], pc});
    chunk_valid = 1'b0; chunk_last = 1'b0;
    step();
    chk("short_err_clr", err_len, 1'b0);
    chk("short_nostart2", net_start, 1'b0);

    // A correct frame after the short one
    run_frame(pd, pe, 2'b01);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("f2_back_load", chunk_ready, 1'b1);

    // Reset in the middle of RUN
    chunk_valid = 1'b1; chunk_data = ones; chunk_last = 1'b0;
    step();
    chunk_data = fives; chunk_last = 1'b1;
    step();
    chunk_valid = 1'b0; chunk_last = 1'b0;
    repeat (100) step();
    chk("mid_run_en", net_en, 1'b1);
    rst_n = 1'b0;
    step();
    chk("mrst_en", net_en, 1'b0);
    chk("mrst_ready", chunk_ready, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_idx", chunk_idx, 2'd0);
    chk("mrst_image", image, 800'd0);
    chk("mrst_result", result, 2'b00);
    rst_n = 1'b1;
    step();
    chk("mrst_en2", net_en, 1'b0);
    chk("mrst_busy2", busy, 1'b0);

    // Small configuration: 2 chunks of 32 bits, 1-cycle run window
    acc = 0; s_en = 0; rv_at = -1;
    s_net_out = 2'b01;
    for (int i = 0; i < 8; i++) begin
      if (rv_at < 0) begin
        s_chunk_valid = 1'b1;
        s_chunk_data  = (i == 0) ? 32'h1234_5678 : (i == 1) ? 32'h9ABC_DEF0 : 32'h0BAD_F00D;
        s_chunk_last  = (i == 1);
      end else begin
        s_chunk_valid = 1'b0;
        s_chunk_last  = 1'b0;
      end
      if (s_chunk_valid && s_chunk_ready) acc++;
      if (s_net_en) s_en++;
      s_net_out = s_net_en ? 2'b11 : 2'b01;
      step();
      if (s_result_valid && rv_at < 0) rv_at = i;
    end
    chk("s_accepted", acc, 2);
    chk("s_en_cycles", s_en, 1);
    chk("s_rv_cycle", rv_at, 3);
    chk("s_result", s_result, 2'b11);
    chk("s_rv", s_result_valid, 1'b1);
    chk("s_image", s_image, 64'h9ABC_DEF0_1234_5678);
    chk("s_idx", s_chunk_idx, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
